spi_reg_slave: RTL and testbench
================================

Name: spi_reg_slave

Overview:
SPI slave front end that sits directly upstream of the register bank and gives an external SPI master access to it. Runs entirely in the system clock domain by oversampling sclk, ss_n and mosi. Decodes 16-bit frames (R/W bit, 7-bit address, 8-bit data). For writes, issues a single-cycle write strobe. For reads, returns the bank's combinational read data on miso.

Parameters:
ADDR_W, 7, register address width; frame header is 1 + ADDR_W bits
DATA_W, 8, register data width
SYNC_STAGES, 2, flip-flop depth of the input synchronizers for sclk/ss_n/mosi (min 2)

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master, mode 0 (CPOL=0, CPHA=0), asynchronous to clk
ss_n  input  1  slave select, active-low, asynchronous
mosi  input  1  master-out data, MSB first
miso  output  1  slave-out data, MSB first
miso_oe  output  1  miso output enable for the pad tristate; high only during the read data phase
address  output  ADDR_W  register address to the bank; holds its value between frames
data_in  output  DATA_W  write data to the bank
wr  output  1  write strobe to the bank, one clk cycle per write frame
data_out  input  DATA_W  combinational read data from the bank for the current address
busy  output  1  high while a frame is in progress (ss_n low after sync)
frame_err  output  1  one-cycle pulse when a frame aborts before completion

Behaviour:
- Reset (rst=0, async): miso=0, miso_oe=0, address=0, data_in=0, wr=0, busy=0, frame_err=0, FSM=IDLE, bit counter=0, synchronizer flops=1 for ss_n and 0 for sclk/mosi.
- Synchronizers: SYNC_STAGES flops per input. Edge detect on synced sclk uses one extra flop. An edge takes effect SYNC_STAGES+1 clk after the pin transition. Requirement: f_clk >= 8 x f_sclk.
- Frame format: bit0 = R/W (1=read, 0=write), then ADDR_W address bits MSB first, then DATA_W data bits. mosi is sampled on synced sclk rising edges; miso changes on synced sclk falling edges.
- States:
  - IDLE: synced ss_n falling -> HDR, clear bit counter, busy=1.
  - HDR: shift mosi on each rise. After bit 1+ADDR_W, load address and go to WDATA (R/W=0) or RLOAD (R/W=1).
  - WDATA: shift DATA_W bits into data_in shadow. On the last rise, drive data_in and pulse wr for exactly 1 clk, then go to DONE.
  - RLOAD: one clk after address is updated, capture data_out into the tx shift register, set miso=tx[MSB] and miso_oe=1, then go to RDATA. Capture happens within 2 clk of the last header rise, i.e. before the next sclk fall.
  - RDATA: on each sclk fall, shift tx left and drive the next bit. After DATA_W rises, go to DONE. miso_oe stays 1 until ss_n deasserts.
  - DONE: ignore further sclk edges (no second write, no counter wrap). Synced ss_n rising -> IDLE, busy=0, miso_oe=0, miso=0.
- Abort: synced ss_n rises in HDR/WDATA/RLOAD/RDATA -> IDLE, frame_err=1 for 1 clk, no wr, miso_oe=0. address keeps any value already loaded; data_in unchanged.
- ss_n and sclk events in the same clk: ss_n takes priority (frame ends, sclk edge discarded).
- wr is never asserted outside WDATA completion. address/data_in are stable for the whole wr cycle and stay stable after it.
- Latency: wr asserts SYNC_STAGES+2 clk after the 16th sclk rising pin edge.
- Reset mid-frame: immediate return to reset values. The frame in progress is dropped and frame_err is not pulsed.

Test Plan:
- Write frame: ss_n low, shift 0x05 (W, addr 5) then data 0xA7, ss_n high -> exactly one wr pulse with address=5, data_in=0xA7; busy rises/falls with ss_n; frame_err=0.
- Read frame: bank model returns 0x3C at address 0x12; shift 0x92 then 8 dummy clocks -> master samples 0x3C on miso (MSB first); miso_oe=1 only in the data phase; no wr.
- Abort: ss_n rises after 11 sclk rising edges of a write to addr 3 -> frame_err pulses once, wr never asserts, FSM back in IDLE; the next full write to addr 3 with data 0x55 succeeds.
- Over-clocking: write frame 0x7F/0xFF followed by 5 extra sclk pulses before ss_n high -> single wr (address=0x7F, data_in=0xFF); extra clocks ignored.
- Back-to-back: two write frames (addr 1/0x11, addr 2/0x22) with ss_n high for 3 clk between them -> two wr pulses with the correct pairs; address holds 2 afterwards.
- Async reset mid-read: assert rst=0 during the read data phase -> all outputs return to reset values immediately; after release, a read of addr 0 returns the bank value.

Source files
------------

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 slave giving an external master access to the register bank
// Oversamples sclk/ss_n/mosi in the clk domain; 16-bit frames of R/W, address, data.
module spi_reg_slave #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss_n,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_in,
    output logic              wr,
    input  logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              frame_err
);

    localparam int LAST_BIT = ADDR_W + DATA_W;
    localparam int CNT_W    = $clog2(ADDR_W + DATA_W + 2);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_WDATA, S_RLOAD, S_RDATA, S_DONE
    } state_t;

    state_t r_state, w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_ss_sync, r_mosi_sync;
    logic                   r_sclk_d, r_ss_d;
    logic [CNT_W-1:0]       r_cnt;
    logic [ADDR_W-1:0]      r_hdr;
    logic [DATA_W-1:0]      r_wshadow;
    logic [DATA_W-1:0]      r_tx;
    logic                   r_wr_pend;

    logic w_sclk_s, w_ss_s, w_mosi_s;
    logic w_rise, w_fall, w_ss_rise, w_ss_fall;
    logic w_hdr_last, w_data_last, w_in_frame;
    logic [ADDR_W:0] w_hdr_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_sync <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sclk_d    <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sclk_d    <= w_sclk_s;
            r_ss_d      <= w_ss_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ss_s      = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_rise      = w_sclk_s & ~r_sclk_d;
    assign w_fall      = ~w_sclk_s & r_sclk_d;
    assign w_ss_rise   = w_ss_s & ~r_ss_d;
    assign w_ss_fall   = ~w_ss_s & r_ss_d;
    assign w_hdr_full  = {r_hdr, w_mosi_s};
    assign w_hdr_last  = w_rise && (r_cnt == CNT_W'(ADDR_W));
    assign w_data_last = w_rise && (r_cnt == CNT_W'(LAST_BIT));
    assign w_in_frame  = (r_state == S_HDR) || (r_state == S_WDATA) ||
                         (r_state == S_RLOAD) || (r_state == S_RDATA);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    // ss_n deassertion wins over any sclk edge seen in the same cycle
    always_comb begin
        w_state_nxt = r_state;
        if (r_state != S_IDLE && w_ss_rise) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_ss_fall) w_state_nxt = S_HDR;
                S_HDR:   if (w_hdr_last) w_state_nxt = w_hdr_full[ADDR_W] ? S_RLOAD : S_WDATA;
                S_WDATA: if (w_data_last) w_state_nxt = S_DONE;
                S_RLOAD: w_state_nxt = S_RDATA;
                S_RDATA: if (w_data_last) w_state_nxt = S_DONE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            address   <= '0;
            data_in   <= '0;
            wr        <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            r_cnt     <= '0;
            r_hdr     <= '0;
            r_wshadow <= '0;
            r_tx      <= '0;
            r_wr_pend <= 1'b0;
        end else begin
            // data_in and wr update together one cycle after the last data bit
            wr        <= r_wr_pend;
            r_wr_pend <= 1'b0;
            if (r_wr_pend) data_in <= r_wshadow;
            frame_err <= w_in_frame && w_ss_rise;
            busy      <= (w_state_nxt != S_IDLE);

            if (!w_ss_rise) begin
                case (r_state)
                    S_IDLE: if (w_ss_fall) r_cnt <= '0;
                    S_HDR: if (w_rise) begin
                        r_cnt <= r_cnt + 1'b1;
                        r_hdr <= w_hdr_full[ADDR_W-1:0];
                        if (w_hdr_last) address <= w_hdr_full[ADDR_W-1:0];
                    end
                    S_WDATA: if (w_rise) begin
                        r_cnt     <= r_cnt + 1'b1;
                        r_wshadow <= {r_wshadow[DATA_W-2:0], w_mosi_s};
                        if (w_data_last) r_wr_pend <= 1'b1;
                    end
                    S_RLOAD: begin
                        r_tx    <= data_out;
                        miso    <= data_out[DATA_W-1];
                        miso_oe <= 1'b1;
                    end
                    S_RDATA: begin
                        if (w_rise) r_cnt <= r_cnt + 1'b1;
                        // the fall right after the last header bit must keep the MSB on the line
                        if (w_fall && (r_cnt > CNT_W'(ADDR_W + 1))) begin
                            r_tx <= {r_tx[DATA_W-2:0], 1'b0};
                            miso <= r_tx[DATA_W-2];
                        end
                    end
                    default: ;
                endcase
            end

            if (w_state_nxt == S_IDLE) begin
                miso    <= 1'b0;
                miso_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - scoreboard bench for spi_reg_slave driven by a mode-0 master model
module tb_spi_reg_slave;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe, wr, busy, frame_err;
    logic [6:0] address;
    logic [7:0] data_in, data_out;

    spi_reg_slave #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .address(address), .data_in(data_in),
        .wr(wr), .data_out(data_out), .busy(busy), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    assign data_out = (address == 7'h12) ? 8'h3C : (address == 7'h00) ? 8'hA5 : 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [7:0]  got_rd[$];
    logic        exp_err[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [14:0] e;
        logic [7:0]  g, x;
        if (wr !== 1'b0) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wr_unexpected: got addr 0x%0h data 0x%0h expected no write at %0t",
                         address, data_in, $time);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", address, e[14:8]);
                check("wr_data", data_in, e[7:0]);
            end
        end
        if (frame_err !== 1'b0) begin
            if (exp_err.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_err_unexpected: got 1 expected 0 at %0t", $time);
            end else begin
                void'(exp_err.pop_front());
                check("frame_err_no_wr", wr, 0);
            end
        end
        if (got_rd.size() > 0 && exp_rd.size() > 0) begin
            g = got_rd.pop_front();
            x = exp_rd.pop_front();
            check("rd_data", g, x);
        end
    end

    task automatic spi_shift(input logic [31:0] v, input int n, output logic [7:0] rd,
                             output logic oe_hdr, output logic oe_dat);
        rd = 8'h00;
        oe_hdr = 1'b0;
        oe_dat = 1'b1;
        for (int i = 0; i < n; i++) begin
            mosi = v[31-i];
            #50;
            sclk = 1'b1;
            if (i < 8) oe_hdr = oe_hdr | miso_oe;
            else if (i < 16) begin
                rd = {rd[6:0], miso};
                oe_dat = oe_dat & miso_oe;
            end
            #50;
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] v, input int n, output logic [7:0] rd,
                         output logic oe_hdr, output logic oe_dat);
        ss_n = 1'b0;
        #60;
        spi_shift(v, n, rd, oe_hdr, oe_dat);
        #60;
        ss_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        logic       oh, od;
        #1;
        check("rst_miso", miso, 0);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_address", address, 0);
        check("rst_data_in", data_in, 0);
        check("rst_wr", wr, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_err", frame_err, 0);
        #30 rst = 1'b1;
        #50;

        // write addr 5 <= 0xA7
        exp_wr.push_back({7'h05, 8'hA7});
        ss_n = 1'b0;
        #60;
        check("busy_in_frame", busy, 1);
        spi_shift({8'h05, 8'hA7, 16'h0}, 16, rd, oh, od);
        #60 ss_n = 1'b1;
        #60;
        check("busy_after_frame", busy, 0);
        check("data_in_hold", data_in, 8'hA7);

        // read addr 0x12, bank returns 0x3C
        exp_rd.push_back(8'h3C);
        frame({8'h92, 24'h0}, 16, rd, oh, od);
        got_rd.push_back(rd);
        check("rd_oe_header", oh, 0);
        check("rd_oe_data", od, 1);
        #60;
        check("rd_oe_after", miso_oe, 0);
        check("rd_miso_after", miso, 0);

        // abort write to addr 3 after 11 rises, then a full write
        exp_err.push_back(1'b1);
        frame({8'h03, 8'h55, 16'h0}, 11, rd, oh, od);
        #60;
        check("abort_addr_kept", address, 7'h03);
        check("abort_busy", busy, 0);
        exp_wr.push_back({7'h03, 8'h55});
        frame({8'h03, 8'h55, 16'h0}, 16, rd, oh, od);
        #60;

        // over-clocked frame: 5 extra pulses ignored
        exp_wr.push_back({7'h7F, 8'hFF});
        frame({8'h7F, 8'hFF, 16'h0}, 21, rd, oh, od);
        #60;

        // back-to-back with 3 clk gap
        exp_wr.push_back({7'h01, 8'h11});
        exp_wr.push_back({7'h02, 8'h22});
        frame({8'h01, 8'h11, 16'h0}, 16, rd, oh, od);
        #30;
        frame({8'h02, 8'h22, 16'h0}, 16, rd, oh, od);
        #100;
        check("b2b_addr_hold", address, 7'h02);
        check("b2b_data_hold", data_in, 8'h22);

        // reset during read data phase
        ss_n = 1'b0;
        #60;
        spi_shift({8'h92, 24'h0}, 11, rd, oh, od);
        check("mid_read_oe", miso_oe, 1);
        rst = 1'b0;
        #1;
        check("rst_mid_miso", miso, 0);
        check("rst_mid_oe", miso_oe, 0);
        check("rst_mid_addr", address, 0);
        check("rst_mid_data_in", data_in, 0);
        check("rst_mid_busy", busy, 0);
        ss_n = 1'b1;
        #49 rst = 1'b1;
        #50;
        exp_rd.push_back(8'hA5);
        frame({8'h80, 24'h0}, 16, rd, oh, od);
        got_rd.push_back(rd);
        #100;

        check("left_exp_wr", exp_wr.size(), 0);
        check("left_exp_rd", exp_rd.size(), 0);
        check("left_exp_err", exp_err.size(), 0);
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
